midi_rx_fifo: RTL
=================

MIDI_RX_FIFO -- requirements
Module: midi_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1500000, audio clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, >=4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries; power of 2, >=2.
REQ-005 SHALL have parameter FILTER_FE, default 1, drop active-sense bytes (0xFE) when 1.
REQ-006 SHALL have port i_clk_aud, input, 1, the only clock; all logic on its rising edge.
REQ-007 SHALL have port i_aud_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_rx, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port i_rd, input, 1, consumer pop strobe.
REQ-010 SHALL have port i_clr_err, input, 1, clears sticky error flags.
REQ-011 SHALL have port o_valid, output, 1, FIFO non-empty.
REQ-012 SHALL have port o_data, output, 8, FIFO head byte.
REQ-013 SHALL have port o_count, output, $clog2(FIFO_DEPTH+1), FIFO occupancy.
REQ-014 SHALL have port o_frame_err, output, 1, sticky: a stop bit sampled low.
REQ-015 SHALL have port o_overrun, output, 1, sticky: a byte was dropped because the FIFO was full.

Function
REQ-016 SHALL pass i_rx through a 2-flop synchronizer (both flops reset to 1); all sampling uses the synchronized value.
REQ-017 SHALL compute DIV = CLK_HZ/(BAUD*OVERSAMPLE) - 1 at elaboration; tick is one cycle high when the tick counter equals DIV, after which the counter wraps to 0.
REQ-018 SHALL clear the tick counter to 0 on the IDLE->START transition, aligning sampling to the detected falling edge.
REQ-019 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-020 IDLE: synchronized rx low -> START with sample count 0.
REQ-021 START: on the tick completing OVERSAMPLE/2 ticks, rx low -> DATA with sample and bit counts 0; rx high -> IDLE (glitch reject, nothing pushed).
REQ-022 DATA: on each OVERSAMPLE-th tick, shift rx into the byte LSB-first; after bit 7 -> STOP.
REQ-023 STOP: on the OVERSAMPLE-th tick, rx high -> push the byte (subject to REQ-025) and go to IDLE; rx low -> set o_frame_err, discard the byte, go to BREAK.
REQ-024 BREAK: remain until synchronized rx is high, then -> IDLE.
REQ-025 When FILTER_FE=1, a received 0xFE SHALL NOT be pushed and SHALL set no flag.
REQ-026 FIFO SHALL be first-word-fall-through: o_data = oldest entry whenever o_valid=1; o_data is don't-care when empty.
REQ-027 A pushed byte SHALL appear on o_data/o_valid on the cycle after the stop-bit sample.
REQ-028 Pop occurs on i_rd & o_valid; i_rd while empty SHALL be ignored with no state change.
REQ-029 Push while full without a same-cycle pop SHALL drop the new byte, set o_overrun, and leave contents unchanged.
REQ-030 Push and pop in the same cycle SHALL both take effect, o_count unchanged; when full this is not an overrun.
REQ-031 Read/write pointers SHALL wrap modulo FIFO_DEPTH; o_count ranges 0..FIFO_DEPTH.
REQ-032 i_clr_err SHALL clear both sticky flags; an error event in the same cycle wins (flag stays set).

Reset
REQ-033 Asserting i_aud_rst_n low SHALL immediately, without a clock, force: state IDLE, all counters 0, FIFO empty, o_valid=0, o_count=0, o_frame_err=0, o_overrun=0, synchronizer=1.
REQ-034 Reset mid-frame SHALL abandon the partial byte; after release, reception SHALL resume on the next falling edge.

Verification (defaults, 48 clocks per bit)
REQ-035 Send 0x90 with a valid stop bit -> o_valid=1, o_data=0x90, o_count=1; i_rd pulse -> o_valid=0, o_count=0.
REQ-036 Send 0xFE: FILTER_FE=1 -> o_count stays 0, no flags; FILTER_FE=0 -> o_data=0xFE.
REQ-037 Send 0x55 with stop bit low, line held low 200 clocks, then high, then 0x3C -> o_frame_err=1, 0x55 not stored, 0x3C received; i_clr_err -> o_frame_err=0.
REQ-038 Drive rx low for 10 clocks only -> no push, state returns to IDLE, no flags set.
REQ-039 Send 0x01..0x05 with no reads -> o_count=4, o_overrun=1; four pops yield 0x01..0x04; pop while full during 5th stop sample -> no overrun.
REQ-040 Assert reset during bit 3 of 0xA5, release, send 0x42 -> all outputs reset to 0, then only 0x42 is received.

Source files
------------

// File: rtl/midi_rx_fifo.sv
// midi_rx_fifo: oversampling MIDI UART receiver feeding a first-word-fall-through byte FIFO
// with sticky framing/overrun flags and optional active-sense (0xFE) filtering.
module midi_rx_fifo #(
    parameter int CLK_HZ     = 1500000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int FILTER_FE  = 1
) (
    input  logic                              i_clk_aud,
    input  logic                              i_aud_rst_n,
    input  logic                              i_rx,
    input  logic                              i_rd,
    input  logic                              i_clr_err,
    output logic                              o_valid,
    output logic [7:0]                        o_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
    output logic                              o_frame_err,
    output logic                              o_overrun
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE) - 1;
    localparam int TW  = DIV > 0 ? $clog2(DIV + 1) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [TW-1:0] DIV_T  = TW'(DIV);
    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] FULL_N = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_d;
    logic [1:0]    sync;
    logic          rx_s;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [SW-1:0] scnt, scnt_d;
    logic [2:0]    bcnt, bcnt_d;
    logic [7:0]    shreg, shreg_d;
    logic          start_det, push, fe_evt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          pop, full, wr, ovf;

    assign rx_s = sync[1];
    assign tick = tcnt == DIV_T;

    always_comb begin
        state_d   = state;
        scnt_d    = tick ? scnt + 1'b1 : scnt;
        bcnt_d    = bcnt;
        shreg_d   = shreg;
        start_det = 1'b0;
        push      = 1'b0;
        fe_evt    = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_d   = START;
                scnt_d    = '0;
                start_det = 1'b1;
            end
            START: if (tick && scnt == S_HALF) begin
                state_d = rx_s ? IDLE : DATA;
                scnt_d  = '0;
                bcnt_d  = '0;
            end
            DATA: if (tick && scnt == S_LAST) begin
                shreg_d = {rx_s, shreg[7:1]};
                scnt_d  = '0;
                bcnt_d  = bcnt + 1'b1;
                state_d = bcnt == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick && scnt == S_LAST) begin
                scnt_d  = '0;
                state_d = rx_s ? IDLE : BREAK;
                push    = rx_s && !(FILTER_FE != 0 && shreg == 8'hFE);
                fe_evt  = !rx_s;
            end
            BREAK: state_d = rx_s ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    // Tick counter restarts on the detected falling edge so samples land mid-bit.
    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) begin
            sync  <= 2'b11;
            state <= IDLE;
            tcnt  <= '0;
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            sync  <= {sync[0], i_rx};
            state <= state_d;
            tcnt  <= (start_det || tick) ? '0 : tcnt + 1'b1;
            scnt  <= scnt_d;
            bcnt  <= bcnt_d;
            shreg <= shreg_d;
        end
    end

    assign pop  = i_rd && o_valid;
    assign full = count == FULL_N;
    assign wr   = push && (!full || pop);
    assign ovf  = push && full && !pop;

    always_ff @(posedge i_clk_aud) begin
        if (wr) mem[wptr] <= shreg;
    end

    always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
        if (!i_aud_rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            wptr        <= wr ? wptr + 1'b1 : wptr;
            rptr        <= pop ? rptr + 1'b1 : rptr;
            count       <= count + CW'(wr) - CW'(pop);
            o_frame_err <= fe_evt || (o_frame_err && !i_clr_err);
            o_overrun   <= ovf || (o_overrun && !i_clr_err);
        end
    end

    assign o_valid = count != '0;
    assign o_count = count;
    assign o_data  = mem[rptr];
endmodule
